// File: rtl/combo_lock_if.sv
// combo_lock_if: button/lock request inputs and status outputs of the combination lock.
//   btn_p     - debounced one-cycle press pulses, one bit per button
//   lock_req  - relock request (level)
//   prog_req  - code programming request (level)
//   unlocked  - high while the lock is open
//   alarm     - sticky alarm after repeated failures
//   err_pulse - one-cycle pulse per failed attempt
//   fail_cnt  - consecutive failed attempts
//   digit_cnt - digits accepted in the current attempt
// master: the side driving the buttons; slave: the lock itself.
interface combo_lock_if;
  logic [3:0] btn_p;
  logic       lock_req;
  logic       prog_req;
  logic       unlocked;
  logic       alarm;
  logic       err_pulse;
  logic [2:0] fail_cnt;
  logic [2:0] digit_cnt;

  modport master (
    output btn_p, lock_req, prog_req,
    input  unlocked, alarm, err_pulse, fail_cnt, digit_cnt
  );

  modport slave (
    input  btn_p, lock_req, prog_req,
    output unlocked, alarm, err_pulse, fail_cnt, digit_cnt
  );
endinterface

// File: rtl/combo_lock.sv
// combo_lock: checks debounced button presses against a stored entry code.
// Drives a timed unlock, a one-cycle error pulse per failed attempt and a
// sticky alarm after MAX_FAIL consecutive failures.
// Ports:
//   clk   - system clock
//   rst_l - asynchronous active-low reset
//   bus   - combo_lock_if.slave (btn_p, lock_req, prog_req in;
//           unlocked, alarm, err_pulse, fail_cnt, digit_cnt out, all registered)
// Optional feature macro: COMBO_LOCK_PROGRAM_EN
//   defined   - code lives in a register (reset to CODE) and can be
//               reprogrammed from the open state via prog_req
//   undefined - code is the CODE constant; prog_req is ignored
module combo_lock #(
  parameter int unsigned             CODE_LEN    = 4,
  parameter logic [2*CODE_LEN-1:0]   CODE        = 8'b11_01_00_10,
  parameter int unsigned             TIMEOUT_CYC = 50_000_000,
  parameter int unsigned             UNLOCK_CYC  = 250_000_000,
  parameter int unsigned             MAX_FAIL    = 3
) (
  input  logic         clk,
  input  logic         rst_l,
  combo_lock_if.slave  bus
);

  localparam int unsigned TMAX = (TIMEOUT_CYC > UNLOCK_CYC) ? TIMEOUT_CYC : UNLOCK_CYC;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]     UN_LAST   = TW'(UNLOCK_CYC - 1);
  localparam logic [2:0]        LAST_DIG  = 3'(CODE_LEN - 1);
  localparam logic [2:0]        MAX_F     = 3'(MAX_FAIL);
  localparam logic [7:0][1:0]   CODE_INIT = 16'(CODE);

`ifdef COMBO_LOCK_PROGRAM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_OPEN  = 3'd2,
    S_ALARM = 3'd3,
    S_PROG  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_OPEN  = 3'd2,
    S_ALARM = 3'd3
  } state_t;
`endif

  state_t          r_state, nxt_state;
  logic [2:0]      r_digit, nxt_digit;
  logic            r_mis, nxt_mis;
  logic [TW-1:0]   r_timer, nxt_timer;
  logic [2:0]      r_fail, nxt_fail;
  logic            r_unl, nxt_unl;
  logic            r_alarm, nxt_alarm;
  logic            r_err, nxt_err;

  logic [7:0][1:0] w_code;
  logic            w_press;
  logic            w_onehot;
  logic [1:0]      w_idx;
  logic            w_bad;
  logic            w_last;
  logic            w_hold_off;
  logic [2:0]      w_fail_inc;
  logic            w_do_pass;
  logic            w_do_fail;

`ifdef COMBO_LOCK_PROGRAM_EN
  logic [7:0][1:0] r_code, nxt_code;
  logic [7:0][1:0] r_new, nxt_new;
  assign w_code = r_code;
`else
  logic w_unused_prog;
  assign w_unused_prog = bus.prog_req;
  assign w_code        = CODE_INIT;
`endif

  // Button pulse decode: any set bit is an event, only a single set bit is a usable digit.
  always_comb begin
    w_onehot = 1'b0;
    w_idx    = 2'd0;
    case (bus.btn_p)
      4'b0001: begin w_onehot = 1'b1; w_idx = 2'd0; end
      4'b0010: begin w_onehot = 1'b1; w_idx = 2'd1; end
      4'b0100: begin w_onehot = 1'b1; w_idx = 2'd2; end
      4'b1000: begin w_onehot = 1'b1; w_idx = 2'd3; end
      default: ;
    endcase
  end

  assign w_press    = |bus.btn_p;
  // r_digit is always 0 in IDLE, so the same lookup serves the first digit.
  assign w_bad      = !w_onehot || (w_idx != w_code[r_digit]);
  assign w_last     = (r_state == S_IDLE) ? (CODE_LEN == 32'd1) : (r_digit == LAST_DIG);
  assign w_fail_inc = (r_fail >= MAX_F) ? r_fail : r_fail + 3'd1;
  // Single-digit codes can fail on back-to-back presses; swallow the press
  // right after a failure so err_pulse never stays high two cycles running.
  assign w_hold_off = (CODE_LEN == 32'd1) && r_err;

  // Next-state and next-output logic.
  always_comb begin
    nxt_state = r_state;
    nxt_digit = r_digit;
    nxt_mis   = r_mis;
    nxt_timer = r_timer;
    nxt_fail  = r_fail;
    nxt_unl   = r_unl;
    nxt_alarm = r_alarm;
    nxt_err   = 1'b0;
    w_do_pass = 1'b0;
    w_do_fail = 1'b0;
`ifdef COMBO_LOCK_PROGRAM_EN
    nxt_code  = r_code;
    nxt_new   = r_new;
`endif

    case (r_state)
      S_IDLE: begin
        nxt_timer = '0;
        if (w_press && !w_hold_off) begin
          if (w_last) begin
            w_do_pass = !w_bad;
            w_do_fail = w_bad;
          end else begin
            nxt_state = S_ENTRY;
            nxt_digit = 3'd1;
            nxt_mis   = w_bad;
          end
        end
      end

      S_ENTRY: begin
        // A press on the timeout edge wins over the timeout.
        if (w_press) begin
          nxt_timer = '0;
          if (w_last) begin
            w_do_pass = !(r_mis || w_bad);
            w_do_fail = r_mis || w_bad;
          end else begin
            nxt_digit = r_digit + 3'd1;
            nxt_mis   = r_mis | w_bad;
          end
        end else if (r_timer == TO_LAST) begin
          w_do_fail = 1'b1;
        end else begin
          nxt_timer = r_timer + TW'(1);
        end
      end

      S_OPEN: begin
        if (bus.lock_req || (r_timer == UN_LAST)) begin
          nxt_state = S_IDLE;
          nxt_unl   = 1'b0;
          nxt_timer = '0;
`ifdef COMBO_LOCK_PROGRAM_EN
        end else if (bus.prog_req) begin
          nxt_state = S_PROG;
          nxt_digit = 3'd0;
          nxt_timer = '0;
          nxt_new   = r_code;
`endif
        end else begin
          nxt_timer = r_timer + TW'(1);
        end
      end

`ifdef COMBO_LOCK_PROGRAM_EN
      S_PROG: begin
        // New digits collect in r_new; r_code only changes on a complete entry.
        if (w_onehot) begin
          nxt_timer          = '0;
          nxt_new[r_digit]   = w_idx;
          if (r_digit == LAST_DIG) begin
            nxt_code  = nxt_new;
            nxt_state = S_IDLE;
            nxt_unl   = 1'b0;
            nxt_digit = 3'd0;
          end else begin
            nxt_digit = r_digit + 3'd1;
          end
        end else if (r_timer == TO_LAST) begin
          nxt_state = S_IDLE;
          nxt_unl   = 1'b0;
          nxt_digit = 3'd0;
          nxt_timer = '0;
        end else begin
          nxt_timer = r_timer + TW'(1);
        end
      end
`endif

      S_ALARM: begin
        nxt_alarm = 1'b1;
      end

      default: begin
        nxt_state = S_IDLE;
      end
    endcase

    // Attempt outcome, shared by IDLE (single-digit codes) and ENTRY.
    if (w_do_pass) begin
      nxt_state = S_OPEN;
      nxt_unl   = 1'b1;
      nxt_fail  = 3'd0;
      nxt_timer = '0;
      nxt_digit = 3'd0;
      nxt_mis   = 1'b0;
    end
    if (w_do_fail) begin
      nxt_err   = 1'b1;
      nxt_fail  = w_fail_inc;
      nxt_digit = 3'd0;
      nxt_mis   = 1'b0;
      nxt_timer = '0;
      if (w_fail_inc == MAX_F) begin
        nxt_state = S_ALARM;
        nxt_alarm = 1'b1;
      end else begin
        nxt_state = S_IDLE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= S_IDLE;
      r_digit <= 3'd0;
      r_mis   <= 1'b0;
      r_timer <= '0;
      r_fail  <= 3'd0;
      r_unl   <= 1'b0;
      r_alarm <= 1'b0;
      r_err   <= 1'b0;
`ifdef COMBO_LOCK_PROGRAM_EN
      r_code  <= CODE_INIT;
      r_new   <= CODE_INIT;
`endif
    end else begin
      r_state <= nxt_state;
      r_digit <= nxt_digit;
      r_mis   <= nxt_mis;
      r_timer <= nxt_timer;
      r_fail  <= nxt_fail;
      r_unl   <= nxt_unl;
      r_alarm <= nxt_alarm;
      r_err   <= nxt_err;
`ifdef COMBO_LOCK_PROGRAM_EN
      r_code  <= nxt_code;
      r_new   <= nxt_new;
`endif
    end
  end

  assign bus.unlocked  = r_unl;
  assign bus.alarm     = r_alarm;
  assign bus.err_pulse = r_err;
  assign bus.fail_cnt  = r_fail;
  assign bus.digit_cnt = r_digit;

endmodule

// File: tb/tb_combo_lock.sv
// tb_combo_lock: scoreboard bench for combo_lock. The driver pushes the
// reference model's expected outputs for every applied cycle; a monitor pops
// and compares them one time unit after each rising edge.
module tb_combo_lock;

  localparam int unsigned CODE_LEN    = 4;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned UNLOCK_CYC  = 8;
  localparam int unsigned MAX_FAIL    = 3;
  localparam logic [7:0]  CODE        = 8'b11_01_00_10;
`ifdef COMBO_LOCK_PROGRAM_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic clk;
  logic rst_l;

  combo_lock_if bus ();

  combo_lock #(
    .CODE_LEN    (CODE_LEN),
    .CODE        (CODE),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .UNLOCK_CYC  (UNLOCK_CYC),
    .MAX_FAIL    (MAX_FAIL)
  ) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       unl;
    logic       alm;
    logic       err;
    logic [2:0] fc;
    logic [2:0] dc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: attempt is a list of entered digits (-1 = multi-button press).
  int m_code[4];
  int m_entry[$];
  int m_prog_q[$];
  bit m_open, m_prog, m_alarm, m_err;
  int m_quiet, m_age, m_fails;

  function automatic int btn_idx(input logic [3:0] b);
    if ($countones(b) != 1) return -1;
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_code = '{2, 0, 1, 3};
    m_entry.delete();
    m_prog_q.delete();
    m_open = 0; m_prog = 0; m_alarm = 0; m_err = 0;
    m_quiet = 0; m_age = 0; m_fails = 0;
  endtask

  task automatic model_fail();
    m_err = 1;
    m_fails++;
    m_entry.delete();
    if (m_fails == MAX_FAIL) m_alarm = 1;
  endtask

  task automatic model_step(input logic [3:0] b, input bit lk, input bit pg);
    bit ok;
    m_err = 0;
    if (m_alarm) return;
    if (m_prog) begin
      if (btn_idx(b) >= 0) begin
        m_prog_q.push_back(btn_idx(b));
        m_quiet = 0;
        if (m_prog_q.size() == CODE_LEN) begin
          for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prog_q[i];
          m_prog = 0;
          m_prog_q.delete();
        end
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT_CYC) begin
          m_prog = 0;
          m_prog_q.delete();
        end
      end
    end else if (m_open) begin
      m_age++;
      if (lk || m_age == UNLOCK_CYC) begin
        m_open = 0;
      end else if (PROG_EN && pg) begin
        m_open = 0;
        m_prog = 1;
        m_quiet = 0;
        m_prog_q.delete();
      end
    end else if (b != 4'b0000) begin
      m_entry.push_back(btn_idx(b));
      m_quiet = 0;
      if (m_entry.size() == CODE_LEN) begin
        ok = 1;
        for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 0;
        if (ok) begin
          m_open = 1; m_age = 0; m_fails = 0;
          m_entry.delete();
        end else begin
          model_fail();
        end
      end
    end else if (m_entry.size() > 0) begin
      m_quiet++;
      if (m_quiet == TIMEOUT_CYC) model_fail();
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.unl = m_open || m_prog;
    e.alm = m_alarm;
    e.err = m_err;
    e.fc  = 3'(m_fails);
    e.dc  = m_prog ? 3'(m_prog_q.size()) : 3'(m_entry.size());
    return e;
  endfunction

  task automatic step(input logic [3:0] b, input bit lk, input bit pg);
    @(negedge clk);
    rst_l        = 1'b1;
    bus.btn_p    = b;
    bus.lock_req = lk;
    bus.prog_req = pg;
    model_step(b, lk, pg);
    exp_q.push_back(model_out());
  endtask

  task automatic step_rst();
    @(negedge clk);
    rst_l        = 1'b0;
    bus.btn_p    = 4'b0000;
    bus.lock_req = 1'b0;
    bus.prog_req = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b0);
  endtask

  // Four presses, each followed by gap idle cycles.
  task automatic press4(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3, input int gap);
    step(d0, 1'b0, 1'b0); idle(gap);
    step(d1, 1'b0, 1'b0); idle(gap);
    step(d2, 1'b0, 1'b0); idle(gap);
    step(d3, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per applied cycle.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{unl: bus.unlocked, alm: bus.alarm, err: bus.err_pulse,
                fc: bus.fail_cnt, dc: bus.digit_cnt};
        n_vec++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got unl=%0b alarm=%0b err=%0b fail_cnt=%0d digit_cnt=%0d, expected unl=%0b alarm=%0b err=%0b fail_cnt=%0d digit_cnt=%0d",
                   $time, got.unl, got.alm, got.err, got.fc, got.dc,
                   e.unl, e.alm, e.err, e.fc, e.dc);
        end
      end
    end
  end

  initial begin
    logic [3:0] b;
    bit         lk, pg;
    int         r, k, tgt;

    rst_l        = 1'b0;
    bus.btn_p    = 4'b0000;
    bus.lock_req = 1'b0;
    bus.prog_req = 1'b0;
    model_reset();

    step_rst(); step_rst();
    idle(2);

    // Correct code, presses 3 cycles apart, then let the unlock time out.
    press4(4'b0100, 4'b0001, 4'b0010, 4'b1000, 2);
    idle(12);

    // Wrong third digit.
    press4(4'b0100, 4'b0001, 4'b0001, 4'b1000, 2);
    idle(4);

    // Inter-digit timeout, then a press landing on the exact timeout edge.
    step_rst();
    step(4'b0100, 1'b0, 1'b0); idle(18);
    step(4'b0100, 1'b0, 1'b0); idle(15);
    step(4'b0001, 1'b0, 1'b0); idle(3);

    // Three wrong attempts raise the alarm; a correct code then stays locked.
    step_rst();
    for (int a = 0; a < 3; a++) begin
      press4(4'b1000, 4'b0001, 4'b0010, 4'b1000, 1);
      idle(2);
    end
    press4(4'b0100, 4'b0001, 4'b0010, 4'b1000, 1);
    idle(3);
    step_rst();
    step(4'b0100, 1'b0, 1'b0);
    step_rst();
    idle(2);

    // Multi-button press fails the attempt; early relock from the open state.
    press4(4'b0100, 4'b0011, 4'b0010, 4'b1000, 1);
    idle(2);
    press4(4'b0100, 4'b0001, 4'b0010, 4'b1000, 1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    idle(3);

    // Programming request: reprograms when enabled, ignored otherwise.
    step_rst();
    press4(4'b0100, 4'b0001, 4'b0010, 4'b1000, 1);
    step(4'b0000, 1'b0, 1'b1);
    press4(4'b1000, 4'b1000, 4'b0001, 4'b0001, 1);
    idle(10);
    press4(4'b0100, 4'b0001, 4'b0010, 4'b1000, 1);
    idle(3);
    press4(4'b1000, 4'b1000, 4'b0001, 4'b0001, 1);
    idle(10);

    // Randomized traffic, biased toward the currently expected digit.
    step_rst();
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3 || (m_alarm && r < 60)) begin
        step_rst();
      end else begin
        b  = 4'b0000;
        lk = ($urandom_range(0, 99) < 4);
        pg = ($urandom_range(0, 99) < 6);
        if ($urandom_range(0, 99) < 15) begin
          k = int'($urandom_range(0, 9));
          if (k < 7) begin
            tgt = (m_entry.size() < CODE_LEN) ? m_code[m_entry.size()]
                                              : int'($urandom_range(0, 3));
            b = 4'(1 << tgt);
          end else if (k < 9) begin
            b = 4'(1 << $urandom_range(0, 3));
          end else begin
            b = 4'($urandom_range(1, 15));
          end
        end
        step(b, lk, pg);
      end
    end

    idle(2);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
